// File: rtl/mult_accum_core.sv
// Three-stage signed multiply-accumulate: operand registers, product register, accumulator.
// Optional macro MULT_ACCUM_CORE_SAT_EN makes the accumulator saturate instead of wrap.
module mult_accum_core #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned ACC_W  = 18
) (
    input  logic              clock0,
    input  logic              rstn,
    input  logic [DATA_W-1:0] dataa,
    input  logic [DATA_W-1:0] datab,
    output logic [ACC_W-1:0]  result
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [DATA_W-1:0] a_q;
    logic signed [DATA_W-1:0] b_q;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  prod_ext_c;
    logic signed [ACC_W-1:0]  acc_nxt_c;

    // Product is full precision; widen both operands before multiplying
    always_ff @(posedge clock0 or negedge rstn) begin
        if (!rstn) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            a_q    <= $signed(dataa);
            b_q    <= $signed(datab);
            prod_q <= PROD_W'(a_q) * PROD_W'(b_q);
            acc_q  <= acc_nxt_c;
        end
    end

`ifdef MULT_ACCUM_CORE_SAT_EN
    logic signed [ACC_W:0] sum_wide_c;

    // One guard bit detects overflow; clamp toward the sign of the true sum
    always_comb begin
        prod_ext_c = ACC_W'(prod_q);
        sum_wide_c = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext_c);
        acc_nxt_c  = sum_wide_c[ACC_W-1:0];
        if (sum_wide_c[ACC_W] != sum_wide_c[ACC_W-1]) begin
            if (sum_wide_c[ACC_W]) begin
                acc_nxt_c = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                acc_nxt_c = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end
`else
    // Plain two's complement wrap
    always_comb begin
        prod_ext_c = ACC_W'(prod_q);
        acc_nxt_c  = acc_q + prod_ext_c;
    end
`endif

    assign result = acc_q;

endmodule

// File: tb/tb_mult_accum_core.sv
// Randomised self-checking bench for mult_accum_core against a sum-of-products model.
// Honours MULT_ACCUM_CORE_SAT_EN when the design is built with it.
module tb_mult_accum_core;

    localparam int unsigned DATA_W = 9;
    localparam int unsigned ACC_W  = 18;

    logic              clock0 = 1'b0;
    logic              rstn   = 1'b1;
    logic [DATA_W-1:0] dataa  = '0;
    logic [DATA_W-1:0] datab  = '0;
    logic [ACC_W-1:0]  result;

    int errors = 0;
    int checks = 0;

    // Model: every product sampled since reset release, and the expected sum
    longint hist[$];
    longint golden = 0;

    mult_accum_core #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clock0(clock0),
        .rstn  (rstn),
        .dataa (dataa),
        .datab (datab),
        .result(result)
    );

    always #5 clock0 = ~clock0;

    function automatic longint acc_add(input longint g, input longint p);
        longint s;
        longint hi;
        longint lo;
        logic [ACC_W-1:0] t;
        s  = g + p;
        hi = (longint'(1) << (ACC_W - 1)) - 1;
        lo = -(longint'(1) << (ACC_W - 1));
`ifdef MULT_ACCUM_CORE_SAT_EN
        t = '0;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
`else
        t = ACC_W'(s);
        if (hi < lo) return 0;
        return longint'($signed(t));
`endif
    endfunction

    task automatic check_val(input string tag, input longint want);
        logic [ACC_W-1:0] exp_v;
        exp_v = ACC_W'(want);
        checks++;
        if (result !== exp_v) begin
            errors++;
            $display("FAIL %s: result=%0d expected=%0d", tag, $signed(result), $signed(exp_v));
        end
    endtask

    // Apply one operand pair across one rising edge and compare against the model
    task automatic step(input int a, input int b, input string tag);
        dataa = DATA_W'(a);
        datab = DATA_W'(b);
        @(posedge clock0);
        #1;
        hist.push_back(longint'(a) * longint'(b));
        if (hist.size() >= 3) golden = acc_add(golden, hist[hist.size() - 3]);
        check_val(tag, golden);
    endtask

    task automatic do_reset();
        dataa = DATA_W'(5);
        datab = DATA_W'(7);
        #2;
        rstn = 1'b0;
        #1;
        check_val("reset_async", 0);
        repeat (3) @(posedge clock0);
        #1;
        check_val("reset_held", 0);
        hist.delete();
        golden = 0;
        @(negedge clock0);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_constant();
        int exp_tab[6];
        exp_tab = '{0, 0, 12, 24, 36, 48};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(3, 4, "const_model");
            check_val("const_table", longint'(exp_tab[i]));
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(-9, 9, "alt_neg");
            step(9, 9, "alt_pos");
        end
    endtask

    task automatic test_extreme();
        do_reset();
        step(-256, -256, "extreme_first");
        for (int i = 0; i < 4; i++) step(0, 0, "extreme_hold");
        check_val("extreme_value", 65536);
        do_reset();
        step(255, -256, "extreme_mixed");
        step(0, 0, "extreme_mixed");
        step(0, 0, "extreme_mixed");
        check_val("extreme_mixed_value", -65280);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 6; i++) step(255, 255, "wrap_hold");
        for (int i = 0; i < 3; i++) step(-1, 1, "wrap_tail");
        for (int i = 0; i < 3; i++) step(-256, 255, "wrap_neg");
    endtask

    task automatic test_random_reset();
        do_reset();
        for (int i = 0; i < 20; i++)
            step(int'($urandom_range(18)) - 9, int'($urandom_range(18)) - 9, "rand_pre");
        #2;
        rstn = 1'b0;
        #1;
        check_val("rand_async_clear", 0);
        hist.delete();
        golden = 0;
        @(posedge clock0);
        #1;
        check_val("rand_in_reset", 0);
        @(negedge clock0);
        rstn = 1'b1;
        for (int i = 0; i < 20; i++)
            step(int'($urandom_range(18)) - 9, int'($urandom_range(18)) - 9, "rand_post");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 40; i++)
            step(int'($urandom_range(511)) - 256, int'($urandom_range(511)) - 256, "b2b_full");
    endtask

    initial begin
        test_reset();
        test_constant();
        test_alternate();
        test_extreme();
        test_wrap();
        test_random_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
